// File: rtl/quant_gain_pkg.sv
// quant_gain_pkg
// Shared defaults, cfg_ctrl bit positions and FSM encoding for the
// quantiser gain scheduler.
package quant_gain_pkg;

  localparam int QG_ADDR_W     = 10;
  localparam int QG_GAIN_W     = 16;
  localparam int QG_CNT_W      = 8;

  localparam int WR_TOGGLE_BIT = 31;
  localparam int SWAP_ARM_BIT  = 30;

  // state    | meaning
  // ST_IDLE  | active bank stable, no swap pending
  // ST_ARMED | swap pending, taken on the next sync_in
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } qg_state_e;

endpackage

// File: rtl/quant_gain_ram.sv
// quant_gain_ram
// Simple dual-port gain table: one write port, one registered read port.
// Read-first: a read and write to the same address in one cycle returns
// the old word. Contents are not reset.
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (sampled every cycle)
//   o_rdata  read data, one cycle after i_raddr
module quant_gain_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/quant_gain_sched.sv
// quant_gain_sched
// Double-buffered per-channel gain table. Software fills the shadow bank
// through cfg_ctrl/cfg_data; an armed swap takes effect on the next
// sync_in so gains never change mid-spectrum. The active gain for each
// incoming channel sample is streamed out two cycles later.
//   user_clk, user_rst_n     clock, async active-low reset
//   cfg_ctrl, cfg_data       software control / data words
//   sync_in, din_valid       frame sync and sample strobe
//   gain_out, gain_valid     gain for the sample, valid strobe (2 cycles)
//   sync_out                 sync_in delayed by 2 cycles
//   bank_sel, armed          active bank, swap pending
//   swap_count, wr_collide   completed swaps, sticky write/swap collision
module quant_gain_sched
  import quant_gain_pkg::*;
#(
  parameter int ADDR_W = QG_ADDR_W,
  parameter int GAIN_W = QG_GAIN_W,
  parameter int CNT_W  = QG_CNT_W
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       cfg_ctrl,
  input  logic [31:0]       cfg_data,
  input  logic              sync_in,
  input  logic              din_valid,
  output logic [GAIN_W-1:0] gain_out,
  output logic              gain_valid,
  output logic              sync_out,
  output logic              bank_sel,
  output logic              armed,
  output logic [CNT_W-1:0]  swap_count,
  output logic              wr_collide
);

  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reset asserts asynchronously, releases two clocks after user_rst_n rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  qg_state_e         r_state, w_state_nxt;
  logic              r_wr_q, r_arm_q;
  logic              r_bank_sel;
  logic [CNT_W-1:0]  r_swap_count;
  logic              r_wr_collide;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_vld_d1, r_sync_d1;
  logic              r_gain_valid, r_sync_out;
  logic [GAIN_W-1:0] r_gain_out;

  logic              w_wr, w_arm_rise, w_swap, w_bank_nxt;
  logic [ADDR_W-1:0] w_idx;
  logic [GAIN_W-1:0] w_rd_data;
  logic              w_unused;

  assign w_wr       = cfg_ctrl[WR_TOGGLE_BIT] ^ r_wr_q;
  assign w_arm_rise = cfg_ctrl[SWAP_ARM_BIT] & ~r_arm_q;
  assign w_swap     = (r_state == ST_ARMED) & sync_in;
  assign w_bank_nxt = r_bank_sel ^ w_swap;
  assign w_idx      = sync_in ? '0 : r_cnt;
  assign w_unused   = ^{cfg_data[31:GAIN_W], cfg_ctrl[29:ADDR_W]};

  // Arm and sync in the same IDLE cycle only arms; the swap needs a later sync.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_arm_rise) w_state_nxt = ST_ARMED;
      ST_ARMED: if (sync_in)    w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_q       <= 1'b0;
      r_arm_q      <= 1'b0;
      r_bank_sel   <= 1'b0;
      r_swap_count <= '0;
      r_wr_collide <= 1'b0;
      r_cnt        <= '0;
      r_vld_d1     <= 1'b0;
      r_sync_d1    <= 1'b0;
      r_gain_valid <= 1'b0;
      r_sync_out   <= 1'b0;
      r_gain_out   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_q    <= cfg_ctrl[WR_TOGGLE_BIT];
      r_arm_q   <= cfg_ctrl[SWAP_ARM_BIT];
      if (w_swap) begin
        r_bank_sel   <= ~r_bank_sel;
        r_swap_count <= r_swap_count + CNT_ONE;
      end
      if (w_swap && w_wr) r_wr_collide <= 1'b1;
      if (din_valid)    r_cnt <= w_idx + IDX_ONE;
      else if (sync_in) r_cnt <= '0;
      r_vld_d1     <= din_valid;
      r_sync_d1    <= sync_in;
      r_gain_valid <= r_vld_d1;
      r_sync_out   <= r_sync_d1;
      if (r_vld_d1) r_gain_out <= w_rd_data;
    end
  end

  // Writes target the pre-swap shadow bank; reads use the post-swap bank,
  // so a colliding write lands in the bank that just became active.
  quant_gain_ram #(
    .ADDR_W (ADDR_W + 1),
    .DATA_W (GAIN_W)
  ) u_ram (
    .i_clk   (user_clk),
    .i_we    (w_wr & w_rst_n),
    .i_waddr ({~r_bank_sel, cfg_ctrl[ADDR_W-1:0]}),
    .i_wdata (cfg_data[GAIN_W-1:0]),
    .i_raddr ({w_bank_nxt, w_idx}),
    .o_rdata (w_rd_data)
  );

  assign gain_out   = r_gain_out;
  assign gain_valid = r_gain_valid;
  assign sync_out   = r_sync_out;
  assign bank_sel   = r_bank_sel;
  assign armed      = (r_state == ST_ARMED);
  assign swap_count = r_swap_count;
  assign wr_collide = r_wr_collide;

endmodule
